// File: rtl/dcache_multiway_if.sv
// CPU-side and memory-side signal bundle for dcache_multiway.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dcache_multiway_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int BANKNUM  = 4
);
  logic [ADDRBITS-1:0] dcache_addr;
  logic                dcache_rdreq;
  logic                dcache_wrreq;
  logic [DATABITS-1:0] dcache_in;
  logic [BANKNUM-1:0]  byteenable;
  logic [DATABITS-1:0] dcache_out;
  logic                dcache_out_valid;
  logic                dcache_busy;
  logic [ADDRBITS-1:0] mem_addr;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_out;
  logic [DATABITS-1:0] mem_in;
  logic                mem_in_valid;
  logic                mem_ack;
  logic                flush_all;
  logic                flush_done;

  modport slave (
    input  dcache_addr, dcache_rdreq, dcache_wrreq, dcache_in, byteenable,
           mem_in, mem_in_valid, mem_ack, flush_all,
    output dcache_out, dcache_out_valid, dcache_busy,
           mem_addr, mem_rdreq, mem_wrreq, mem_out, flush_done
  );

  modport master (
    output dcache_addr, dcache_rdreq, dcache_wrreq, dcache_in, byteenable,
           mem_in, mem_in_valid, mem_ack, flush_all,
    input  dcache_out, dcache_out_valid, dcache_busy,
           mem_addr, mem_rdreq, mem_wrreq, mem_out, flush_done
  );
endinterface

// File: rtl/dcache_multiway.sv
// Fully-associative write-back data cache with internal evict/fill/flush FSM.
// Define DCACHE_LRU_EN for LRU replacement; otherwise a round-robin pointer picks victims.
module dcache_multiway #(
  parameter int DATABITS      = 32,
  parameter int ADDRBITS      = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int BANKNUM       = 4,
  parameter int WAYS          = 2,
  parameter int WAYBITS       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  dcache_multiway_if.slave bus
);
  localparam int WORDS   = 1 << CACHEADDRBITS;
  localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - 2;
  localparam logic [CACHEADDRBITS-1:0] LAST_WORD = CACHEADDRBITS'(WORDS - 1);
  localparam logic [CACHEADDRBITS-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {IDLE, EVICT, FILL, FLUSH, DONE} state_t;

  state_t                   r_state;
  logic [TAGBITS-1:0]       r_tag [WAYS];
  logic [WAYS-1:0]          r_valid;
  logic [WAYS-1:0]          r_dirty;
  logic [DATABITS-1:0]      r_data [WAYS][WORDS];
  logic [TAGBITS-1:0]       r_req_tag;
  logic [WAYBITS-1:0]       r_victim;
  logic [CACHEADDRBITS-1:0] r_cnt;
  logic [WAYBITS:0]         r_scan;
  logic                     r_flushing;

  logic [DATABITS-1:0]      r_out;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [ADDRBITS-1:0]      r_mem_addr;
  logic                     r_mem_rdreq;
  logic                     r_mem_wrreq;
  logic [DATABITS-1:0]      r_mem_out;
  logic                     r_flush_done;

  logic [TAGBITS-1:0]       w_tag;
  logic [CACHEADDRBITS-1:0] w_offset;
  logic                     w_hit;
  logic [WAYBITS-1:0]       w_hit_way;
  logic                     w_has_inv;
  logic [WAYBITS-1:0]       w_inv_way;
  logic [WAYBITS-1:0]       w_repl_way;
  logic [WAYBITS-1:0]       w_victim;
  logic [WAYBITS-1:0]       w_scan_way;
  logic                     w_idle_req;
  logic                     w_wr_hit;
  logic                     w_rd_hit;
  logic                     w_fill_we;
  logic                     w_fill_last;
  logic                     w_unused;

  assign w_tag      = bus.dcache_addr[ADDRBITS-1:CACHEADDRBITS+2];
  assign w_offset   = bus.dcache_addr[CACHEADDRBITS+1:2];
  assign w_unused   = &{1'b0, bus.dcache_addr[1:0]};
  assign w_scan_way = r_scan[WAYBITS-1:0];

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_valid[i] && r_tag[i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAYBITS'(i);
      end
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAYBITS'(i);
      end
    end
  end

  // Write wins over read when both are held; flush_all wins over both.
  assign w_idle_req  = (r_state == IDLE) && !bus.flush_all && (bus.dcache_rdreq || bus.dcache_wrreq);
  assign w_wr_hit    = w_idle_req && bus.dcache_wrreq && w_hit;
  assign w_rd_hit    = w_idle_req && !bus.dcache_wrreq && w_hit;
  assign w_fill_we   = (r_state == FILL) && bus.mem_in_valid;
  assign w_fill_last = w_fill_we && (r_cnt == LAST_WORD);

`ifdef DCACHE_LRU_EN
  logic [WAYBITS-1:0] r_age [WAYS];
  logic               w_touch;
  logic [WAYBITS-1:0] w_touch_way;

  always_comb begin
    w_repl_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_age[i] == WAYBITS'(WAYS - 1)) w_repl_way = WAYBITS'(i);
    end
  end

  assign w_touch     = w_wr_hit || w_rd_hit || w_fill_last;
  assign w_touch_way = (r_state == FILL) ? r_victim : w_hit_way;

  // Ages stay a permutation: only ways younger than the touched one grow older.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WAYS; i++) r_age[i] <= WAYBITS'(i);
    end else if (w_touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (WAYBITS'(i) == w_touch_way)          r_age[i] <= '0;
        else if (r_age[i] < r_age[w_touch_way])  r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`else
  logic [WAYBITS-1:0] r_rr;

  assign w_repl_way = r_rr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_rr <= '0;
    else if (w_fill_last) r_rr <= r_rr + 1'b1;
  end
`endif

  assign w_victim = w_has_inv ? w_inv_way : w_repl_way;

  // NOTE: the data array has no reset; valid bits already make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      for (int b = 0; b < BANKNUM; b++) begin
        if (bus.byteenable[b]) r_data[w_hit_way][w_offset][b*8 +: 8] <= bus.dcache_in[b*8 +: 8];
      end
    end
    if (w_fill_we) r_data[r_victim][r_cnt] <= bus.mem_in;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      for (int i = 0; i < WAYS; i++) r_tag[i] <= '0;
      r_req_tag    <= '0;
      r_victim     <= '0;
      r_cnt        <= '0;
      r_scan       <= '0;
      r_flushing   <= 1'b0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_rdreq  <= 1'b0;
      r_mem_wrreq  <= 1'b0;
      r_mem_out    <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.flush_all) begin
            r_state <= FLUSH;
            r_busy  <= 1'b1;
            r_scan  <= '0;
          end else if (w_wr_hit) begin
            r_dirty[w_hit_way] <= 1'b1;
          end else if (w_rd_hit) begin
            r_out       <= r_data[w_hit_way][w_offset];
            r_out_valid <= 1'b1;
          end else if (w_idle_req) begin
            r_busy     <= 1'b1;
            r_victim   <= w_victim;
            r_req_tag  <= w_tag;
            r_cnt      <= '0;
            r_flushing <= 1'b0;
            if (r_dirty[w_victim]) begin
              r_state     <= EVICT;
              r_mem_wrreq <= 1'b1;
              r_mem_addr  <= {r_tag[w_victim], ZERO_WORD, 2'b00};
              r_mem_out   <= r_data[w_victim][ZERO_WORD];
            end else begin
              r_state     <= FILL;
              r_mem_rdreq <= 1'b1;
              r_mem_addr  <= {w_tag, ZERO_WORD, 2'b00};
            end
          end
        end
        EVICT: begin
          if (bus.mem_ack) begin
            if (r_cnt == LAST_WORD) begin
              r_dirty[r_victim] <= 1'b0;
              r_cnt             <= '0;
              r_mem_wrreq       <= 1'b0;
              if (r_flushing) begin
                r_state <= FLUSH;
                r_scan  <= r_scan + 1'b1;
              end else begin
                r_state     <= FILL;
                r_mem_rdreq <= 1'b1;
                r_mem_addr  <= {r_req_tag, ZERO_WORD, 2'b00};
              end
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= {r_tag[r_victim], r_cnt + 1'b1, 2'b00};
              r_mem_out  <= r_data[r_victim][r_cnt + 1'b1];
            end
          end
        end
        FILL: begin
          if (bus.mem_in_valid) begin
            if (r_cnt == LAST_WORD) begin
              r_tag[r_victim]   <= r_req_tag;
              r_valid[r_victim] <= 1'b1;
              r_dirty[r_victim] <= 1'b0;
              r_cnt             <= '0;
              r_mem_rdreq       <= 1'b0;
              r_busy            <= 1'b0;
              r_state           <= IDLE;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= {r_req_tag, r_cnt + 1'b1, 2'b00};
            end
          end
        end
        FLUSH: begin
          if (r_scan == (WAYBITS+1)'(WAYS)) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end else if (r_dirty[w_scan_way]) begin
            r_state     <= EVICT;
            r_victim    <= w_scan_way;
            r_flushing  <= 1'b1;
            r_cnt       <= '0;
            r_mem_wrreq <= 1'b1;
            r_mem_addr  <= {r_tag[w_scan_way], ZERO_WORD, 2'b00};
            r_mem_out   <= r_data[w_scan_way][ZERO_WORD];
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dcache_out       = r_out;
  assign bus.dcache_out_valid = r_out_valid;
  assign bus.dcache_busy      = r_busy;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_rdreq        = r_mem_rdreq;
  assign bus.mem_wrreq        = r_mem_wrreq;
  assign bus.mem_out          = r_mem_out;
  assign bus.flush_done       = r_flush_done;
endmodule

// File: tb/tb_dcache_multiway.sv
// Scoreboard bench for dcache_multiway (WAYS=2, 4-word lines): stimulus queues expected
// read data, memory transactions and flush pulses; monitor processes pop and compare.
module tb_dcache_multiway;
  localparam int DATABITS      = 32;
  localparam int ADDRBITS      = 32;
  localparam int CACHEADDRBITS = 2;
  localparam int BANKNUM       = 4;
  localparam int WAYS          = 2;
  localparam int WAYBITS       = 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dcache_multiway_if #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS), .BANKNUM(BANKNUM)) bus ();

  dcache_multiway #(
    .DATABITS(DATABITS), .ADDRBITS(ADDRBITS), .CACHEADDRBITS(CACHEADDRBITS),
    .BANKNUM(BANKNUM), .WAYS(WAYS), .WAYBITS(WAYBITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_rd [$];
  mem_txn_t    exp_mem [$];
  int          n_flush_req  = 0;
  int          n_flush_seen = 0;
  logic [31:0] mem [logic [31:0]];
  bit          stall = 1'b0;
  bit          stray_req = 1'b0;
  int          fill_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Backing memory: preset words, otherwise {addr[15:0], ~addr[15:0]}.
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic expect_mem(bit wr, logic [31:0] a, logic [31:0] d);
    mem_txn_t e;
    if (exp_mem.size() == 0) begin
      fail($sformatf("mem_unexpected wr=%0d addr=%0h", wr, a));
    end else begin
      e = exp_mem.pop_front();
      check("mem_kind_addr", {31'd0, wr, a}, {31'd0, e.wr, e.addr});
      if (e.wr) check("mem_wb_data", d, e.data);
    end
  endtask

  // Memory model: answers every other cycle so the cache must wait on handshakes.
  always @(negedge clk) begin
    bus.mem_ack      = 1'b0;
    bus.mem_in_valid = 1'b0;
    stall = ~stall;
    if (stray_req) begin
      bus.mem_ack      = 1'b1;
      bus.mem_in_valid = 1'b1;
      bus.mem_in       = 32'hBAD0BAD0;
    end else if (reset_n && !stall) begin
      if (bus.mem_wrreq) begin
        expect_mem(1'b1, bus.mem_addr, bus.mem_out);
        mem[bus.mem_addr] = bus.mem_out;
        bus.mem_ack = 1'b1;
      end else if (bus.mem_rdreq) begin
        expect_mem(1'b0, bus.mem_addr, 32'h0);
        bus.mem_in       = mem_rd(bus.mem_addr);
        bus.mem_in_valid = 1'b1;
        fill_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.dcache_out_valid) begin
      if (exp_rd.size() == 0) fail($sformatf("rd_unexpected data=%0h", bus.dcache_out));
      else check("rd_data", bus.dcache_out, exp_rd.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.flush_done) begin
      check("flush_done_busy", bus.dcache_busy, 1);
      if (n_flush_seen >= n_flush_req) fail("flush_done_unexpected");
      n_flush_seen++;
    end
  end

  task automatic push_fill(logic [31:0] base);
    for (int w = 0; w < 4; w++) exp_mem.push_back('{wr: 1'b0, addr: base + 32'(4*w), data: 32'h0});
  endtask

  task automatic push_wb(logic [31:0] a, logic [31:0] d);
    exp_mem.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n           = 1'b0;
    bus.dcache_rdreq  = 1'b0;
    bus.dcache_wrreq  = 1'b0;
    bus.flush_all     = 1'b0;
    bus.dcache_addr   = '0;
    bus.dcache_in     = '0;
    bus.byteenable    = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {bus.dcache_out_valid, bus.dcache_busy, bus.mem_rdreq, bus.mem_wrreq, bus.flush_done}, 0);
    check("rst_dcache_out", bus.dcache_out, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_out", bus.mem_out, 0);
    reset_n = 1'b1;
  endtask

  // Holds the request until the cache services it in IDLE; checks miss/hit timing.
  task automatic cpu_op(bit wr, bit also_rd, logic [31:0] a, logic [31:0] d, logic [3:0] be, bit exp_miss);
    bit prev_busy;
    bit done = 1'b0;
    @(negedge clk);
    bus.dcache_addr  = a;
    bus.dcache_in    = d;
    bus.byteenable   = be;
    bus.dcache_wrreq = wr;
    bus.dcache_rdreq = !wr || also_rd;
    prev_busy = bus.dcache_busy;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) check($sformatf("busy_after_req_%0h", a), bus.dcache_busy, exp_miss);
      if (!prev_busy && !bus.dcache_busy) begin
        check($sformatf("valid_latency_%0h", a), bus.dcache_out_valid, !wr);
        done = 1'b1;
        break;
      end
      prev_busy = bus.dcache_busy;
    end
    if (!done) fail($sformatf("cpu_timeout_%0h", a));
    bus.dcache_rdreq = 1'b0;
    bus.dcache_wrreq = 1'b0;
  endtask

  task automatic do_flush();
    bit done = 1'b0;
    @(negedge clk);
    bus.flush_all = 1'b1;
    n_flush_req++;
    @(negedge clk);
    bus.flush_all = 1'b0;
    check("flush_busy", bus.dcache_busy, 1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (n_flush_seen == n_flush_req && !bus.dcache_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("flush_timeout");
  endtask

  initial begin
    int start_cnt;
    bit reached;
    mem[32'h104] = 32'h11223344;

    // Phase A: fill, hit, partial write, second fill, replacement.
    apply_reset();
    push_fill(32'h100);
    exp_rd.push_back(mem_rd(32'h100));
    cpu_op(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
    exp_rd.push_back(32'h11223344);
    cpu_op(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 4'b0011, 1'b0);
    exp_rd.push_back(32'h1122BEEF);
    cpu_op(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0);
    push_fill(32'h200);
    exp_rd.push_back(mem_rd(32'h200));
    cpu_op(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1);
    exp_rd.push_back(mem_rd(32'h100));
    cpu_op(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
`ifndef DCACHE_LRU_EN
    push_wb(32'h100, 32'h0100FEFF);
    push_wb(32'h104, 32'h1122BEEF);
    push_wb(32'h108, 32'h0108FEF7);
    push_wb(32'h10C, 32'h010CFEF3);
`endif
    push_fill(32'h300);
    exp_rd.push_back(mem_rd(32'h300));
    cpu_op(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1);
    // Read and write together: the write lands, no read strobe.
    cpu_op(1'b1, 1'b1, 32'h308, 32'h12345678, 4'b1111, 1'b0);
    exp_rd.push_back(32'h12345678);
    cpu_op(1'b0, 1'b0, 32'h308, 32'h0, 4'h0, 1'b0);

    // Phase B: two dirty lines, flush in way order, flush with nothing dirty.
    apply_reset();
    push_fill(32'h400);
    exp_rd.push_back(mem_rd(32'h400));
    cpu_op(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    push_fill(32'h500);
    exp_rd.push_back(mem_rd(32'h500));
    cpu_op(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, 1'b1);
    cpu_op(1'b1, 1'b0, 32'h408, 32'hCAFEF00D, 4'b1111, 1'b0);
    cpu_op(1'b1, 1'b0, 32'h50C, 32'h0BADC0DE, 4'b1100, 1'b0);
    push_wb(32'h400, 32'h0400FBFF);
    push_wb(32'h404, 32'h0404FBFB);
    push_wb(32'h408, 32'hCAFEF00D);
    push_wb(32'h40C, 32'h040CFBF3);
    push_wb(32'h500, 32'h0500FAFF);
    push_wb(32'h504, 32'h0504FAFB);
    push_wb(32'h508, 32'h0508FAF7);
    push_wb(32'h50C, 32'h0BADFAF3);
    do_flush();
    check("flush_wb_drained", exp_mem.size(), 0);
    do_flush();
    // Stray memory strobes while idle must not disturb the cache.
    @(posedge clk);
    #1 stray_req = 1'b1;
    @(posedge clk);
    #1 stray_req = 1'b0;
    exp_rd.push_back(32'hCAFEF00D);
    cpu_op(1'b0, 1'b0, 32'h408, 32'h0, 4'h0, 1'b0);
    exp_rd.push_back(32'h0BADFAF3);
    cpu_op(1'b0, 1'b0, 32'h50C, 32'h0, 4'h0, 1'b0);

    // Phase C: reset in the middle of a fill.
    apply_reset();
    exp_mem.push_back('{wr: 1'b0, addr: 32'h600, data: 32'h0});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h604, data: 32'h0});
    start_cnt = fill_cnt;
    @(negedge clk);
    bus.dcache_addr  = 32'h600;
    bus.dcache_rdreq = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (fill_cnt - start_cnt >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) fail("fill_progress_timeout");
    #1;
    check("rdreq_before_reset", bus.mem_rdreq, 1);
    reset_n          = 1'b0;
    bus.dcache_rdreq = 1'b0;
    #1;
    check("rdreq_async_drop", bus.mem_rdreq, 0);
    check("busy_async_drop", bus.dcache_busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_fill(32'h600);
    exp_rd.push_back(mem_rd(32'h600));
    cpu_op(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1);

    repeat (4) @(negedge clk);
    check("mem_queue_empty", exp_mem.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("flush_pulse_count", n_flush_seen, n_flush_req);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
